// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// ps2_host_tx_pkg : state encodings and command constants for the PS/2 host
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Last data-phase bit index before the stop bit is driven.
  localparam logic [3:0] LAST_SHIFT_BIT  = 4'd9;

  // Host frame payload as shifted out LSB first: {odd parity, data}.
  function automatic logic [8:0] ps2_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// ps2_line_sync : 2-flop synchronizers for PS/2 clock/data plus clock fall detect
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_meta_q,  clk_meta_d;
  logic clk_sync_q,  clk_sync_d;
  logic clk_prev_q,  clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_sync  = clk_sync_q;
  assign data_sync = data_sync_q;
  assign fall      = clk_prev_q & ~clk_sync_q;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter with ack check and watchdog
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  import ps2_host_tx_pkg::*;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);

  logic clk_sync;
  logic data_sync;
  logic fall;

  ps2_line_sync u_line_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  tx_state_e        state_q,    state_d;
  logic [8:0]       shift_q,    shift_d;
  logic [3:0]       bitcnt_q,   bitcnt_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             clk_oe_q,   clk_oe_d;
  logic             data_oe_q,  data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             ack_ok_q,   ack_ok_d;
  logic             ack_seen_q, ack_seen_d;

  logic wd_active;
  logic timeout;

  assign wd_active = (state_q == ST_RTS) || (state_q == ST_SHIFT) ||
                     (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout   = wd_active && (cnt_q == TIMEOUT_LIM);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    cnt_d      = cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ack_ok_d   = ack_ok_q;
    ack_seen_d = ack_seen_q;

    // Watchdog: cycles since the last device clock fall, saturating.
    if (wd_active) begin
      if (fall) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != TIMEOUT_LIM) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d    = ps2_frame(tx_data);
          bitcnt_d   = 4'd0;
          cnt_d      = '0;
          ack_ok_d   = 1'b0;
          ack_seen_d = 1'b0;
          clk_oe_d   = 1'b1;
          state_d    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q >= INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RTS: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bitcnt_d  = 4'd1;
          state_d   = ST_SHIFT;
        end
      end

      // Bits 1..7 and parity go out on successive falls, then the stop bit.
      ST_SHIFT: begin
        if (fall) begin
          if (bitcnt_q == LAST_SHIFT_BIT) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bitcnt_d  = bitcnt_q + 4'd1;
          end
        end
      end

      ST_ACK: begin
        if (fall) begin
          ack_seen_d = ~data_sync;
          state_d    = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d   = 1'b1;
          ack_ok_d = ack_seen_q;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // A stalled device overrides whatever the fall handling decided this cycle.
    if (timeout) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      ack_ok_d  = ack_ok_q;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end

    tx_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_ok_q   <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      cnt_q      <= cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_ok_q   <= ack_ok_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = ~tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ack_ok      = ack_ok_q;

endmodule

`default_nettype wire
